// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package ifb_pkg;

    localparam int IFB_ADDR_W   = 32;
    localparam int IFB_DATA_W   = 32;
    localparam int IFB_DEPTH    = 4;
    localparam int PTR_W        = $clog2(IFB_DEPTH);
    localparam int IMEM_LATENCY = 1;

    typedef struct packed {
        logic [IFB_ADDR_W-1:0] pc;
        logic [IFB_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush and async active-high reset.
module ifb_fifo
    import ifb_pkg::*;
#(
    parameter int W     = $bits(fetch_entry_t),
    parameter int DEPTH = IFB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !flush && (count != FULL);
    assign do_pop  = pop && !flush && (count != '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch stage: issues imem reads with slot credit, queues {pc, instr} for decode.
// Define IFB_BYPASS_EN to present a response combinationally when the FIFO is empty.
module ifetch_buffer
    import ifb_pkg::*;
#(
    parameter int ADDR_W = IFB_ADDR_W,
    parameter int DATA_W = IFB_DATA_W,
    parameter int DEPTH  = IFB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        pc_in,
    input  logic                     pc_valid,
    output logic                     pc_ready,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [DATA_W-1:0]        imem_rdata,
    input  logic                     flush,
    output logic                     if_valid,
    input  logic                     if_ready,
    output logic [DATA_W-1:0]        if_instr,
    output logic [ADDR_W-1:0]        if_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = ADDR_W + DATA_W;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

    logic              inflight;
    logic [ADDR_W-1:0] pc_q;
    logic              resp;
    logic              push;
    logic              pop;
    logic [CW:0]       occ;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     fifo_rdata;
    logic [EW-1:0]     head;

    // An in-flight request already owns a slot, so a response always fits.
    assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign pc_ready  = !flush && (occ < CREDIT_MAX);
    assign imem_req  = pc_valid && pc_ready;
    assign imem_addr = pc_in;

    assign resp  = inflight && !flush;
    assign wdata = {pc_q, imem_rdata};
    assign pop   = (count != '0) && if_ready && !flush;

`ifdef IFB_BYPASS_EN
    logic bypass;
    assign bypass   = resp && (count == '0);
    assign push     = resp && !(bypass && if_ready);
    assign if_valid = (count != '0) || bypass;
    assign head     = bypass ? wdata : fifo_rdata;
`else
    assign push     = resp;
    assign if_valid = (count != '0);
    assign head     = fifo_rdata;
`endif

    assign {if_pc, if_instr} = if_valid ? head : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            pc_q     <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) pc_q <= pc_in;
        end
    end

    ifb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (fifo_rdata),
        .count (count)
    );

endmodule

// File: tb/tb_ifetch_buffer.sv
// Scoreboard bench for ifetch_buffer: queue-level reference model, randomized traffic.
module tb_ifetch_buffer;
    import ifb_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
`ifdef IFB_BYPASS_EN
    localparam int LAT = IMEM_LATENCY;
`else
    localparam int LAT = IMEM_LATENCY + 1;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              flush;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic [2:0]        count;

    always #5 clk = ~clk;

    ifetch_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .pc_ready   (pc_ready),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .flush      (flush),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .count      (count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory answers one cycle after a strobe; otherwise returns junk.
    always @(posedge clk) imem_rdata <= imem_req ? imem_f(imem_addr) : $urandom();

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT output against the head of the expected stream.
    always @(negedge clk) begin
        int   n_fifo;
        int   lat;
        logic exp_v;
        #2;
        if (!rst) begin
            n_fifo = 0;
            foreach (exp_q[i]) if (exp_q[i].acc + 2 <= cyc) n_fifo++;
            lat   = flush ? 2 : LAT;
            exp_v = (exp_q.size() > 0) && (exp_q[0].acc + lat <= cyc);
            chk("if_valid", 64'(if_valid), 64'(exp_v));
            chk("count", 64'(count), 64'(n_fifo));
            if (exp_v && if_valid) begin
                chk("if_pc", 64'(if_pc), 64'(exp_q[0].pc));
                chk("if_instr", 64'(if_instr), 64'(exp_q[0].instr));
                if (if_ready && !flush) void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; the expected entry is queued when a fetch is accepted.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, output logic acc);
        logic er;
        int   c;
        exp_t e;
        @(negedge clk);
        pc_valid = v;
        pc_in    = pc;
        if_ready = rdy;
        flush    = fl;
        #1;
        c  = cyc;
        er = !fl && (exp_q.size() < DEPTH);
        chk("pc_ready", 64'(pc_ready), 64'(er));
        chk("imem_req", 64'(imem_req), 64'(v && er));
        if (v && er) chk("imem_addr", 64'(imem_addr), 64'(pc));
        acc = v && er;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else if (acc) begin
            e.pc    = pc;
            e.instr = imem_f(pc);
            e.acc   = c;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        pc_valid = 1'b0;
        if_ready = 1'b0;
        flush    = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_if_valid", 64'(if_valid), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_if_pc", 64'(if_pc), 64'(0));
        chk("rst_if_instr", 64'(if_instr), 64'(0));
        chk("rst_imem_req", 64'(imem_req), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic        a;
        logic [31:0] npc;
        pc_valid = 1'b0;
        pc_in    = '0;
        if_ready = 1'b0;
        flush    = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_if_valid", 64'(if_valid), 64'(0));
        chk("reset_count", 64'(count), 64'(0));
        chk("reset_if_pc", 64'(if_pc), 64'(0));
        chk("reset_if_instr", 64'(if_instr), 64'(0));
        chk("reset_imem_req", 64'(imem_req), 64'(0));
        rst = 1'b0;

        // Back-to-back stream with decode always ready.
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0, a);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, a);

        // Fill with decode stalled, then drain; PC held until accepted.
        npc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, npc, 1'b0, 1'b0, a);
            if (a) npc++;
        end
        chk("fill_accepts", 64'(npc), 64'(DEPTH));
        for (int i = 0; i < 16; i++) begin
            step(1'b1, npc, 1'b1, 1'b0, a);
            if (a) npc++;
        end
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, a);

        // Three queued plus one in flight, then flush and redirect.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h20 + 32'(i), 1'b0, 1'b0, a);
        step(1'b1, 32'h30, 1'b1, 1'b1, a);
        step(1'b1, 32'h40, 1'b1, 1'b0, a);
        step(1'b1, 32'h41, 1'b1, 1'b0, a);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, a);

        // Reset with three queued and one in flight.
        for (int i = 0; i < 4; i++) step(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0, a);
        do_reset_mid();
        for (int i = 0; i < 6; i++) step(1'b1, 32'h80 + 32'(i), 1'b1, 1'b0, a);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0, a);

        // Randomized traffic with occasional flush and one more reset.
        npc = 32'h100;
        for (int i = 0; i < 800; i++) begin
            logic v, r, f;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 19) == 0);
            if (i == 400) do_reset_mid();
            step(v, npc, r, f, a);
            if (f) npc = $urandom_range(0, 32'hFFFF);
            else if (a) npc++;
        end
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b0, a);
        chk("final_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
